// File: rtl/aes_subshift_seq_pkg.sv
// aes_subshift_seq_pkg: shared constants, FSM state type and ShiftRows index mapping
package aes_subshift_seq_pkg;
   localparam int AES_BYTES = 16;
   localparam int IDX_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // Byte index is column-major (idx = 4*col + row); row r rotates left by r columns.
   function automatic logic [IDX_W-1:0] shiftrows_dest(input logic [IDX_W-1:0] idx);
      logic [1:0] c;
      c = idx[3:2] - idx[1:0];
      return {c, idx[1:0]};
   endfunction
endpackage

// File: rtl/aes_subshift_seq_if.sv
// aes_subshift_seq_if: request/result bus of the SubBytes+ShiftRows engine
//   start     : single-cycle request, accepted only when busy=0
//   state_in  : 128-bit input state, byte i = state_in[127-8i -: 8]
//   busy      : engine occupied (RUN or DONE)
//   done      : one-cycle pulse, state_out valid
//   state_out : 128-bit result state, same byte ordering
interface aes_subshift_seq_if;
   logic         start;
   logic [127:0] state_in;
   logic         busy;
   logic         done;
   logic [127:0] state_out;
   modport master (output start, state_in, input busy, done, state_out);
   modport slave (input start, state_in, output busy, done, state_out);
endinterface

// File: rtl/aes_subshift_seq.sv
// aes_subshift_seq: byte-serial SubBytes (+ optional ShiftRows) through an external shared S-box
//   clk         : system clock
//   rst_n       : synchronous active-low reset
//   bus         : request/result interface (slave side)
//   sbox_a      : byte presented to the external S-box, 0 when not running
//   sbox_result : combinational S-box output for sbox_a
module aes_subshift_seq
   import aes_subshift_seq_pkg::*;
#(
   parameter bit SHIFTROWS_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   aes_subshift_seq_if.slave bus,
   output logic [7:0]        sbox_a,
   input  logic [7:0]        sbox_result
);
   state_t           st;
   logic [IDX_W-1:0] cnt;
   logic [127:0]     st_reg;
   logic [127:0]     out_reg;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] dest;
   assign dest = SHIFTROWS_EN ? shiftrows_dest(cnt) : cnt;
   // Only drive the S-box while running so the shared ISE input stays quiet otherwise.
   assign sbox_a = (st == RUN) ? st_reg[8*(4'd15 - cnt) +: 8] : 8'h00;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.state_out = out_reg;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st <= IDLE;
         cnt <= '0;
         st_reg <= '0;
         out_reg <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (st)
            IDLE: if (bus.start) begin
               st_reg <= bus.state_in;
               cnt <= '0;
               busy <= 1'b1;
               st <= RUN;
            end
            RUN: begin
               out_reg[8*(4'd15 - dest) +: 8] <= sbox_result;
               cnt <= cnt + 1'b1;
               if (cnt == 4'd15) begin
                  done <= 1'b1;
                  st <= DONE;
               end
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
               st <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_subshift_seq.sv
// tb_aes_subshift_seq: randomized self-checking bench for both ShiftRows settings against an arithmetic AES model
module tb_aes_subshift_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   aes_subshift_seq_if b1 ();
   aes_subshift_seq_if b0 ();
   logic [7:0] a1, a0, r1, r0;
   int total = 0;
   int bad = 0;
   localparam logic [127:0] ALL63 = {16{8'h63}};
   localparam logic [127:0] IDX = 128'h000102030405060708090a0b0c0d0e0f;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction
   // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction
   // Reference: out(row r, col c) = S(in(row r, col (c+r) mod 4)) with ShiftRows, else S(in(r,c)).
   function automatic logic [127:0] model(input logic [127:0] s, input bit sr);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            int sc = sr ? (c + r) % 4 : c;
            o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*sc + r) -: 8]);
         end
      return o;
   endfunction
   assign r1 = sbox(a1);
   assign r0 = sbox(a0);
   aes_subshift_seq #(.SHIFTROWS_EN(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .sbox_a(a1), .sbox_result(r1));
   aes_subshift_seq #(.SHIFTROWS_EN(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave), .sbox_a(a0), .sbox_result(r0));
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic drive(input logic s, input logic [127:0] d);
      b1.start = s;
      b0.start = s;
      b1.state_in = d;
      b0.state_in = d;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic op(input logic [127:0] s, output int n);
      drive(1'b1, s);
      tick();
      drive(1'b0, rnd128());
      n = 1;
      while (!b1.done && n < 40) begin
         tick();
         n++;
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, rnd128());
      tick();
      tick();
      total++; if (b1.busy !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b/%b want 0", b1.busy, b0.busy); end
      total++; if (b1.done !== 1'b0 || b0.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b/%b want 0", b1.done, b0.done); end
      total++; if (b1.state_out !== '0 || b0.state_out !== '0) begin bad++; $display("FAIL reset_state_out got %h/%h want 0", b1.state_out, b0.state_out); end
      total++; if (a1 !== 8'h00 || a0 !== 8'h00) begin bad++; $display("FAIL reset_sbox_a got %h/%h want 00", a1, a0); end
      drive(1'b0, '0);
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_zero();
      int n;
      op('0, n);
      total++; if (n !== 17) begin bad++; $display("FAIL zero_latency got %0d want 17", n); end
      total++; if (b0.done !== 1'b1) begin bad++; $display("FAIL zero_done_sr0 got %b want 1", b0.done); end
      total++; if (b1.state_out !== ALL63) begin bad++; $display("FAIL zero_out_sr1 got %h want %h", b1.state_out, ALL63); end
      total++; if (b0.state_out !== ALL63) begin bad++; $display("FAIL zero_out_sr0 got %h want %h", b0.state_out, ALL63); end
      tick();
      total++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin bad++; $display("FAIL zero_idle got busy=%b done=%b want 0/0", b1.busy, b1.done); end
   endtask
   task automatic test_indexed();
      int n = 1;
      drive(1'b1, IDX);
      tick();
      drive(1'b0, ~IDX);
      while (!b1.done && n < 40) begin
         if (n <= 16) begin
            total++; if (a1 !== 8'(n - 1)) begin bad++; $display("FAIL idx_sbox_a cycle %0d got %h want %h", n, a1, 8'(n - 1)); end
         end
         tick();
         n++;
      end
      total++; if (n !== 17) begin bad++; $display("FAIL idx_latency got %0d want 17", n); end
      total++; if (a1 !== 8'h00) begin bad++; $display("FAIL idx_sbox_a_done got %h want 00", a1); end
      total++; if (b1.state_out !== 128'h636b6776f201ab7b30d777c5fe7c6f2b) begin bad++; $display("FAIL idx_out_sr1 got %h want 636b6776f201ab7b30d777c5fe7c6f2b", b1.state_out); end
      total++; if (b0.state_out !== 128'h637c777bf26b6fc53001672bfed7ab76) begin bad++; $display("FAIL idx_out_sr0 got %h want 637c777bf26b6fc53001672bfed7ab76", b0.state_out); end
      total++; if (b1.state_out !== model(IDX, 1'b1)) begin bad++; $display("FAIL idx_model_sr1 got %h want %h", b1.state_out, model(IDX, 1'b1)); end
      tick();
   endtask
   task automatic test_random();
      logic [127:0] s;
      int n;
      repeat (6) begin
         s = rnd128();
         op(s, n);
         total++; if (n !== 17) begin bad++; $display("FAIL rand_latency got %0d want 17", n); end
         total++; if (b1.state_out !== model(s, 1'b1)) begin bad++; $display("FAIL rand_sr1 in %h got %h want %h", s, b1.state_out, model(s, 1'b1)); end
         total++; if (b0.state_out !== model(s, 1'b0)) begin bad++; $display("FAIL rand_sr0 in %h got %h want %h", s, b0.state_out, model(s, 1'b0)); end
         tick();
      end
   endtask
   task automatic test_back_to_back();
      logic [127:0] s1, s2;
      int n;
      s1 = rnd128();
      s2 = rnd128();
      op(s1, n);
      tick();
      total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got %b want 0", b1.busy); end
      op(s2, n);
      total++; if (n !== 17) begin bad++; $display("FAIL b2b_latency got %0d want 17", n); end
      total++; if (b1.state_out !== model(s2, 1'b1)) begin bad++; $display("FAIL b2b_sr1 got %h want %h", b1.state_out, model(s2, 1'b1)); end
      total++; if (b0.state_out !== model(s2, 1'b0)) begin bad++; $display("FAIL b2b_sr0 got %h want %h", b0.state_out, model(s2, 1'b0)); end
      tick();
   endtask
   task automatic test_ignored_start();
      logic [127:0] s, s2, res1, res0;
      int n = 1;
      int dones = 0;
      int dn = 0;
      s = rnd128();
      s2 = ~s;
      res1 = '0;
      res0 = '0;
      drive(1'b1, s);
      tick();
      drive(1'b0, s2);
      while (n < 30) begin
         if (n == 5) drive(1'b1, s2);
         else if (n == 6) drive(1'b0, s2);
         if (b1.done) begin
            dones++;
            dn = n;
            res1 = b1.state_out;
            res0 = b0.state_out;
         end
         tick();
         n++;
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL ign_done_count got %0d want 1", dones); end
      total++; if (dn !== 17) begin bad++; $display("FAIL ign_done_cycle got %0d want 17", dn); end
      total++; if (res1 !== model(s, 1'b1)) begin bad++; $display("FAIL ign_sr1 got %h want %h", res1, model(s, 1'b1)); end
      total++; if (res0 !== model(s, 1'b0)) begin bad++; $display("FAIL ign_sr0 got %h want %h", res0, model(s, 1'b0)); end
      total++; if (b1.busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after got %b want 0", b1.busy); end
   endtask
   task automatic test_midop_reset();
      int n;
      int dones = 0;
      drive(1'b1, rnd128());
      tick();
      drive(1'b0, rnd128());
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++; if (b1.busy !== 1'b0 || b0.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b/%b want 0", b1.busy, b0.busy); end
      total++; if (b1.state_out !== '0) begin bad++; $display("FAIL mid_state_out got %h want 0", b1.state_out); end
      repeat (25) begin
         if (b1.done || b0.done) dones++;
         tick();
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL mid_no_done got %0d want 0", dones); end
      op('0, n);
      total++; if (n !== 17) begin bad++; $display("FAIL mid_latency got %0d want 17", n); end
      total++; if (b1.state_out !== ALL63 || b0.state_out !== ALL63) begin bad++; $display("FAIL mid_out got %h/%h want %h", b1.state_out, b0.state_out, ALL63); end
      tick();
   endtask
   initial begin
      drive(1'b0, '0);
      test_reset();
      test_zero();
      test_indexed();
      test_random();
      test_back_to_back();
      test_ignored_start();
      test_midop_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
